// File: rtl/interrupt_request_resolver_8259a.sv
// ============================================================================
// Module   : interrupt_request_resolver_8259a
// Purpose  : IR pin synchronisers, IRR capture, mask/rotate/nesting resolver
//            driving a registered one-hot interrupt vector.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module interrupt_request_resolver_8259a #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request_pin,
    input  logic       level_or_edge_toggle_mode,
    input  logic       freeze,
    input  logic [7:0] clear_interrupt_request,
    input  logic [7:0] interrupt_mask,
    input  logic       special_mask_mode,
    input  logic [2:0] priority_rotate,
    input  logic [7:0] in_service_register,
    output logic [7:0] interrupt_request_register,
    output logic [7:0] interrupt,
    output logic       interrupt_pending
);

    logic [7:0] r_sync [SYNC_STAGES];
    logic [7:0] r_prev;
    logic [7:0] r_irr;
    logic [7:0] w_sync;

    logic [2:0] w_rot_amt;
    logic [7:0] w_req;
    logic [7:0] w_isr;
    logic [7:0] w_req_rot;
    logic [7:0] w_isr_rot;
    logic [2:0] w_win;
    logic [2:0] w_blk;
    logic       w_grant_ok;
    logic [7:0] w_grant_rot;
    logic [7:0] w_grant;

    function automatic logic [7:0] rotate_right(input logic [7:0] v, input logic [2:0] amt);
        logic [15:0] t;
        t = {v, v} >> amt;
        return t[7:0];
    endfunction

    function automatic logic [7:0] rotate_left(input logic [7:0] v, input logic [2:0] amt);
        logic [15:0] t;
        t = {v, v} << amt;
        return t[15:8];
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 8'h00;
            r_prev <= 8'h00;
        end else begin
            r_sync[0] <= interrupt_request_pin;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Clear outranks freeze, which outranks capture; edge captures are sticky.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_irr
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_irr[i] <= 1'b0;
                end else if (clear_interrupt_request[i]) begin
                    r_irr[i] <= 1'b0;
                end else if (freeze) begin
                    r_irr[i] <= r_irr[i];
                end else if (level_or_edge_toggle_mode) begin
                    r_irr[i] <= w_sync[i];
                end else if (w_sync[i] && !r_prev[i]) begin
                    r_irr[i] <= 1'b1;
                end
            end
        end
    endgenerate

    // After rotating right by rotate+1, bit 0 is the highest-priority level.
    always_comb begin
        w_rot_amt   = priority_rotate + 3'd1;
        w_req       = r_irr & ~interrupt_mask;
        w_isr       = special_mask_mode ? (in_service_register & ~interrupt_mask)
                                        : in_service_register;
        w_req_rot   = rotate_right(w_req, w_rot_amt);
        w_isr_rot   = rotate_right(w_isr, w_rot_amt);
        w_win       = lowest_set(w_req_rot);
        w_blk       = lowest_set(w_isr_rot);
        w_grant_ok  = (w_req_rot != 8'h00) && ((w_isr_rot == 8'h00) || (w_win < w_blk));
        w_grant_rot = w_grant_ok ? (8'h01 << w_win) : 8'h00;
        w_grant     = rotate_left(w_grant_rot, w_rot_amt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interrupt         <= 8'h00;
            interrupt_pending <= 1'b0;
        end else begin
            interrupt         <= w_grant;
            interrupt_pending <= |w_grant;
        end
    end

    assign interrupt_request_register = r_irr;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_request_resolver_8259a.sv
// ============================================================================
// Module   : tb_interrupt_request_resolver_8259a
// Purpose  : Scoreboard bench for the IRR capture and priority resolver.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_interrupt_request_resolver_8259a;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] interrupt_request_pin;
    logic       level_or_edge_toggle_mode;
    logic       freeze;
    logic [7:0] clear_interrupt_request;
    logic [7:0] interrupt_mask;
    logic       special_mask_mode;
    logic [2:0] priority_rotate;
    logic [7:0] in_service_register;
    logic [7:0] interrupt_request_register;
    logic [7:0] interrupt;
    logic       interrupt_pending;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        int         sel;   // 0 = IRR, 1 = interrupt, 2 = pending
        logic [7:0] val;
    } exp_t;
    exp_t sb_q[$];

    interrupt_request_resolver_8259a #(.SYNC_STAGES(2)) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .interrupt_request_pin      (interrupt_request_pin),
        .level_or_edge_toggle_mode  (level_or_edge_toggle_mode),
        .freeze                     (freeze),
        .clear_interrupt_request    (clear_interrupt_request),
        .interrupt_mask             (interrupt_mask),
        .special_mask_mode          (special_mask_mode),
        .priority_rotate            (priority_rotate),
        .in_service_register        (in_service_register),
        .interrupt_request_register (interrupt_request_register),
        .interrupt                  (interrupt),
        .interrupt_pending          (interrupt_pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_irr(input string tag, input logic [7:0] v);
        sb_q.push_back('{tag: {tag, ".irr"}, sel: 0, val: v});
    endtask

    task automatic exp_int(input string tag, input logic [7:0] v);
        sb_q.push_back('{tag: {tag, ".int"}, sel: 1, val: v});
        sb_q.push_back('{tag: {tag, ".pend"}, sel: 2, val: {7'd0, |v}});
    endtask

    task automatic drain();
        exp_t e;
        logic [7:0] got;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       got = interrupt_request_register;
                1:       got = interrupt;
                default: got = {7'd0, interrupt_pending};
            endcase
            check(e.tag, got, e.val);
        end
    endtask

    // Advance n rising edges; outputs are observed 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n                   = 1'b0;
        interrupt_request_pin     = 8'h00;
        level_or_edge_toggle_mode = 1'b0;
        freeze                    = 1'b0;
        clear_interrupt_request   = 8'h00;
        interrupt_mask            = 8'h00;
        special_mask_mode         = 1'b0;
        priority_rotate           = 3'd7;
        in_service_register       = 8'h00;

        // 1: reset with toggling pins, then latency of a single edge request
        for (int i = 0; i < 5; i++) begin
            interrupt_request_pin = 8'($urandom);
            tick(1);
        end
        exp_irr("rst", 8'h00); exp_int("rst", 8'h00);
        drain();
        interrupt_request_pin = 8'h00;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        interrupt_request_pin = 8'h01;
        tick(1);
        exp_irr("lat_k1", 8'h00);
        tick(1); drain();
        exp_irr("lat_k2", 8'h01); exp_int("lat_k2", 8'h00);
        tick(1); drain();
        exp_int("lat_k3", 8'h01);
        tick(1); drain();
        interrupt_request_pin   = 8'h00;
        clear_interrupt_request = 8'h01;
        exp_irr("clr0", 8'h00); exp_int("clr0", 8'h01);
        tick(1); drain();
        clear_interrupt_request = 8'h00;
        exp_int("clr0_next", 8'h00);
        tick(1); drain();

        // 2: edge request survives pin falling, then acknowledged
        interrupt_request_pin = 8'h80;
        tick(1);
        interrupt_request_pin = 8'h00;
        exp_irr("edge_set", 8'h80);
        tick(2); drain();
        exp_irr("edge_hold", 8'h80); exp_int("edge_hold", 8'h80);
        tick(3); drain();
        clear_interrupt_request = 8'h80;
        exp_irr("edge_clr", 8'h00); exp_int("edge_clr", 8'h80);
        tick(1); drain();
        clear_interrupt_request = 8'h00;
        exp_int("edge_clr_next", 8'h00);
        tick(1); drain();

        // 3: level mode follows the pin with lag; freeze holds IRR
        level_or_edge_toggle_mode = 1'b1;
        interrupt_request_pin     = 8'h04;
        tick(1);
        exp_irr("lvl_k1", 8'h00);
        tick(1); drain();
        exp_irr("lvl_k2", 8'h04);
        tick(1); drain();
        interrupt_request_pin = 8'h00;
        exp_irr("lvl_fall_k", 8'h04);
        tick(1); drain();
        exp_irr("lvl_fall_k1", 8'h04);
        tick(1); drain();
        exp_irr("lvl_fall_k2", 8'h00);
        tick(1); drain();
        interrupt_request_pin = 8'h04;
        tick(3);
        freeze                = 1'b1;
        interrupt_request_pin = 8'h00;
        exp_irr("frz_hold", 8'h04);
        tick(4); drain();
        freeze = 1'b0;
        exp_irr("frz_release", 8'h00);
        tick(1); drain();

        // 4: rotating priority
        interrupt_request_pin = 8'h22;
        priority_rotate       = 3'd7;
        exp_int("rot7", 8'h02);
        tick(4); drain();
        priority_rotate = 3'd1;
        exp_int("rot1", 8'h20);
        tick(1); drain();
        interrupt_request_pin = 8'h09;
        priority_rotate       = 3'd3;
        exp_int("rot3_wrap", 8'h01);
        tick(4); drain();

        // 5: in-service nesting and special mask mode
        priority_rotate       = 3'd7;
        in_service_register   = 8'h04;
        interrupt_request_pin = 8'h08;
        exp_int("isr_block", 8'h00);
        tick(4); drain();
        interrupt_request_pin = 8'h02;
        exp_int("isr_higher", 8'h02);
        tick(4); drain();
        interrupt_request_pin = 8'h04;
        exp_int("isr_equal", 8'h00);
        tick(4); drain();
        interrupt_request_pin = 8'h08;
        interrupt_mask        = 8'h04;
        exp_int("mask_no_smm", 8'h00);
        tick(4); drain();
        special_mask_mode = 1'b1;
        exp_int("mask_smm", 8'h08);
        tick(1); drain();
        interrupt_mask = 8'h08;
        exp_int("req_masked", 8'h00);
        tick(1); drain();

        // 6: clear beats set; async reset mid-request
        interrupt_mask            = 8'h00;
        special_mask_mode         = 1'b0;
        in_service_register       = 8'h00;
        level_or_edge_toggle_mode = 1'b0;
        interrupt_request_pin     = 8'h00;
        tick(3);
        clear_interrupt_request = 8'hFF;
        tick(1);
        clear_interrupt_request = 8'h00;
        exp_irr("idle", 8'h00); exp_int("idle", 8'h00);
        tick(1); drain();
        interrupt_request_pin = 8'h10;
        tick(2);
        clear_interrupt_request = 8'h10;
        exp_irr("clr_beats_set", 8'h00);
        tick(1); drain();
        clear_interrupt_request = 8'h00;
        exp_irr("no_reedge", 8'h00);
        tick(1); drain();
        interrupt_request_pin = 8'h00;
        tick(3);
        interrupt_request_pin = 8'h40;
        exp_int("pre_reset", 8'h40);
        tick(4); drain();
        reset_n = 1'b0;
        #1;
        exp_irr("async_rst", 8'h00); exp_int("async_rst", 8'h00);
        drain();
        tick(2);
        reset_n = 1'b1;
        exp_irr("held_thru_rst", 8'h40);
        tick(3); drain();

        check("sb_empty", 8'(sb_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
